// File: rtl/fifo_burst_reader_if.sv
// Output beat stream of fifo_burst_reader: one word per handshake, m_last marks the final beat.
// A beat transfers on a rising edge where m_valid & m_ready; once m_valid rises, m_data and
// m_last stay stable and m_valid stays high until that handshake, and m_ready may toggle freely.
interface fifo_burst_reader_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains burst_len words from a synchronous FIFO read port into a 2-entry skid buffer
// and presents them on a valid/ready stream, tagging the final beat with m_last.
module fifo_burst_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  empty,
    input  logic                  underflow,
    fifo_burst_reader_if.master   m_if,
    output logic [LEN_W-1:0]      words_sent,
    output logic                  err_underflow,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("fifo_burst_reader: FIFO_DEPTH must be at least 1");
    end

    state_t                state_q;
    state_t                state_d;
    logic [LEN_W-1:0]      issue_left;
    logic [LEN_W-1:0]      send_left;
    logic                  inflight;
    logic [1:0]            occ;
    logic [FIFO_WIDTH-1:0] buf0;
    logic [FIFO_WIDTH-1:0] buf1;

    logic       start_acc;
    logic       pop;
    logic       cap;
    logic       uf_hit;
    logic       room;
    logic [1:0] occ_after_pop;

    assign start_acc     = (state_q == IDLE) && start;
    assign pop           = m_if.m_valid && m_if.m_ready;
    assign cap           = inflight && !underflow;
    assign uf_hit        = inflight && underflow;
    assign occ_after_pop = occ - {1'b0, pop};
    // Words buffered plus in flight, after this cycle's pop, must leave a free slot.
    assign room = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign m_if.m_valid = (occ != 2'd0);
    assign m_if.m_data  = buf0;
    assign m_if.m_last  = m_if.m_valid && (send_left == LEN_W'(1));
    assign dbg_state    = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = !empty && (issue_left != '0) && room;
                if (pop && m_if.m_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_left    <= '0;
            send_left     <= '0;
            words_sent    <= '0;
            err_underflow <= 1'b0;
            inflight      <= 1'b0;
            occ           <= 2'd0;
            buf0          <= '0;
            buf1          <= '0;
        end else begin
            inflight <= rd_en;
            if (start_acc) begin
                issue_left    <= burst_len;
                send_left     <= burst_len;
                words_sent    <= '0;
                err_underflow <= 1'b0;
            end else begin
                // A failed read is handed back to the issue counter so it is requested again.
                issue_left <= issue_left - LEN_W'(rd_en) + LEN_W'(uf_hit);
                if (pop) begin
                    send_left  <= send_left - LEN_W'(1);
                    words_sent <= words_sent + LEN_W'(1);
                end
                if (uf_hit) begin
                    err_underflow <= 1'b1;
                end
            end

            // Head always in buf0; a capture lands in the first slot free after this pop.
            if (pop && (occ == 2'd2)) begin
                buf0 <= buf1;
            end
            if (cap) begin
                if (occ_after_pop == 2'd0) begin
                    buf0 <= data_out;
                end else begin
                    buf1 <= data_out;
                end
            end
            occ <= occ_after_pop + {1'b0, cap};
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a queue-backed FIFO model feeds the read port,
// each scenario task drives stimulus and checks its own results inline.
module tb_fifo_burst_reader;
    localparam int W  = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [W-1:0]  data_out;
    logic          empty;
    logic          underflow;
    logic [LW-1:0] words_sent;
    logic          err_underflow;
    logic [1:0]    dbg_state;

    fifo_burst_reader_if #(.FIFO_WIDTH(W)) s_if ();

    fifo_burst_reader #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .LEN_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .burst_len     (burst_len),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .empty         (empty),
        .underflow     (underflow),
        .m_if          (s_if),
        .words_sent    (words_sent),
        .err_underflow (err_underflow),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic         got_last_q[$];
    int           got_cyc_q[$];
    int           rd_cyc_q[$];

    int       done_cnt;
    int       done_cyc;
    logic     busy_at_done;
    int       rd_when_empty;
    int       stall_err;
    int       out_cnt;
    int       max_out;
    int       uf_force_idx = -1;
    int       rd_resp_idx  = 0;
    logic     prev_stall;
    logic [W-1:0] prev_data;
    logic     prev_last;

    task automatic clear_obs();
        exp_q.delete();
        got_q.delete();
        got_last_q.delete();
        got_cyc_q.delete();
        rd_cyc_q.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        busy_at_done  = 1'b1;
        rd_when_empty = 0;
        stall_err     = 0;
        out_cnt       = 0;
        max_out       = 0;
        prev_stall    = 1'b0;
        prev_data     = '0;
        prev_last     = 1'b0;
    endtask

    task automatic push_word(input logic [W-1:0] v);
        fifo_q.push_back(v);
        empty = 1'b0;
    endtask

    // driver: observe at negedge, then play the FIFO's response just after the edge
    task automatic tick();
        logic rd_s;
        logic hs;
        @(negedge clk);
        rd_s = rd_en;
        hs   = s_if.m_valid && s_if.m_ready;
        if (rd_s) begin
            rd_cyc_q.push_back(cyc);
            if (empty) rd_when_empty++;
        end
        if (prev_stall && ((s_if.m_data !== prev_data) || (s_if.m_last !== prev_last))) stall_err++;
        prev_stall = s_if.m_valid && !s_if.m_ready;
        prev_data  = s_if.m_data;
        prev_last  = s_if.m_last;
        if (hs) begin
            got_q.push_back(s_if.m_data);
            got_last_q.push_back(s_if.m_last);
            got_cyc_q.push_back(cyc);
        end
        out_cnt = out_cnt + int'(rd_s) - int'(hs) - int'(underflow);
        if (out_cnt > max_out) max_out = out_cnt;
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (rd_s) begin
            rd_resp_idx++;
            if ((rd_resp_idx == uf_force_idx) || (fifo_q.size() == 0)) begin
                underflow = 1'b1;
            end else begin
                data_out  = fifo_q.pop_front();
                underflow = 1'b0;
            end
        end else begin
            underflow = 1'b0;
        end
        empty = (fifo_q.size() == 0);
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({busy, done, rd_en, s_if.m_valid, s_if.m_last, err_underflow} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, done, rd_en, s_if.m_valid, s_if.m_last, err_underflow});
        end
        n_cmp++;
        if (s_if.m_data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_m_data: got %h expected 0000", s_if.m_data);
        end
        n_cmp++;
        if (words_sent !== 8'd0) begin
            n_err++;
            $display("FAIL reset_words_sent: got %0d expected 0", words_sent);
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int c0;
        int nlast;
        clear_obs();
        for (int i = 1; i <= 5; i++) begin
            push_word(W'(i));
            exp_q.push_back(W'(i));
        end
        s_if.m_ready = 1'b1;
        burst_len    = 8'd5;
        start        = 1'b1;
        c0           = cyc;
        tick();
        start = 1'b0;
        run_until_done(40, ok);
        tick();
        tick();
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL basic_done_seen: got none expected done within 40 cycles");
        end
        n_cmp++;
        if ((rd_cyc_q.size() == 0) || (rd_cyc_q[0] != c0 + 1)) begin
            n_err++;
            $display("FAIL basic_first_rd: got %0d reads expected first at T+1", rd_cyc_q.size());
        end
        n_cmp++;
        if (got_q.size() != 5) begin
            n_err++;
            $display("FAIL basic_beats: got %0d expected 5", got_q.size());
        end
        nlast = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL basic_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
            n_cmp++;
            if (got_cyc_q[i] != c0 + 3 + i) begin
                n_err++;
                $display("FAIL basic_beat_cycle[%0d]: got T+%0d expected T+%0d", i, got_cyc_q[i] - c0, 3 + i);
            end
            if (got_last_q[i]) nlast++;
        end
        n_cmp++;
        if ((nlast != 1) || (got_last_q.size() != 5) || (got_last_q[4] !== 1'b1)) begin
            n_err++;
            $display("FAIL basic_last: got %0d last beats expected 1 on beat 5", nlast);
        end
        n_cmp++;
        if ((done_cyc != c0 + 8) || (done_cnt != 1)) begin
            n_err++;
            $display("FAIL basic_done_time: got T+%0d x%0d expected T+8 x1", done_cyc - c0, done_cnt);
        end
        n_cmp++;
        if (busy_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done);
        end
        n_cmp++;
        if (words_sent !== 8'd5) begin
            n_err++;
            $display("FAIL basic_words_sent: got %0d expected 5", words_sent);
        end
        n_cmp++;
        if (fifo_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_fifo_left: got %0d expected 0", fifo_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int nlast;
        logic [3:0] pat;
        pat = 4'b1001;
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            push_word(16'h0A00 + W'(i));
            exp_q.push_back(16'h0A00 + W'(i));
        end
        s_if.m_ready = 1'b1;
        burst_len    = 8'd8;
        start        = 1'b1;
        tick();
        start = 1'b0;
        ok    = 1'b0;
        for (int i = 1; i < 200; i++) begin
            s_if.m_ready = pat[3 - (i % 4)];
            tick();
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        s_if.m_ready = 1'b1;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL bp_done_seen: got none expected done within 200 cycles");
        end
        n_cmp++;
        if (got_q.size() != 8) begin
            n_err++;
            $display("FAIL bp_beats: got %0d expected 8", got_q.size());
        end
        nlast = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
            if (got_last_q[i]) nlast++;
        end
        n_cmp++;
        if ((nlast != 1) || (got_last_q.size() != 8) || (got_last_q[7] !== 1'b1)) begin
            n_err++;
            $display("FAIL bp_last: got %0d last beats expected 1 on beat 8", nlast);
        end
        n_cmp++;
        if (stall_err != 0) begin
            n_err++;
            $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_err);
        end
        n_cmp++;
        if (max_out > 2) begin
            n_err++;
            $display("FAIL bp_outstanding: got %0d expected at most 2", max_out);
        end
        n_cmp++;
        if ((got_cyc_q.size() != 8) || (done_cyc != got_cyc_q[7] + 1)) begin
            n_err++;
            $display("FAIL bp_done_after_last: got cycle %0d expected one after last handshake", done_cyc);
        end
        n_cmp++;
        if (words_sent !== 8'd8) begin
            n_err++;
            $display("FAIL bp_words_sent: got %0d expected 8", words_sent);
        end
    endtask

    task automatic test_empty_stall();
        bit ok;
        int cp;
        int first_after;
        int nlast;
        clear_obs();
        push_word(16'h0B01);
        push_word(16'h0B02);
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'h0B00 + W'(i));
        s_if.m_ready = 1'b1;
        burst_len    = 8'd4;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        cp = cyc;
        push_word(16'h0B03);
        push_word(16'h0B04);
        run_until_done(40, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL stall_done_seen: got none expected done within 40 cycles");
        end
        n_cmp++;
        if (rd_when_empty != 0) begin
            n_err++;
            $display("FAIL stall_rd_while_empty: got %0d expected 0", rd_when_empty);
        end
        first_after = -1;
        foreach (rd_cyc_q[i]) begin
            if ((first_after < 0) && (rd_cyc_q[i] >= cp)) first_after = rd_cyc_q[i];
        end
        n_cmp++;
        if (first_after != cp) begin
            n_err++;
            $display("FAIL stall_resume: got cycle %0d expected %0d", first_after, cp);
        end
        n_cmp++;
        if (got_q.size() != 4) begin
            n_err++;
            $display("FAIL stall_beats: got %0d expected 4", got_q.size());
        end
        nlast = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL stall_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
            if (got_last_q[i]) nlast++;
        end
        n_cmp++;
        if (nlast != 1) begin
            n_err++;
            $display("FAIL stall_last_count: got %0d expected 1", nlast);
        end
        n_cmp++;
        if (words_sent !== 8'd4) begin
            n_err++;
            $display("FAIL stall_words_sent: got %0d expected 4", words_sent);
        end
    endtask

    task automatic test_zero_and_ignore();
        bit ok;
        int c0;
        clear_obs();
        s_if.m_ready = 1'b1;
        burst_len    = 8'd0;
        start        = 1'b1;
        c0           = cyc;
        tick();
        start = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ((done_cnt != 1) || (done_cyc != c0 + 1)) begin
            n_err++;
            $display("FAIL zero_done: got T+%0d x%0d expected T+1 x1", done_cyc - c0, done_cnt);
        end
        n_cmp++;
        if (rd_cyc_q.size() != 0) begin
            n_err++;
            $display("FAIL zero_no_read: got %0d reads expected 0", rd_cyc_q.size());
        end
        n_cmp++;
        if (words_sent !== 8'd0) begin
            n_err++;
            $display("FAIL zero_words_sent: got %0d expected 0", words_sent);
        end

        clear_obs();
        for (int i = 1; i <= 3; i++) begin
            push_word(16'h0C00 + W'(i));
            exp_q.push_back(16'h0C00 + W'(i));
        end
        s_if.m_ready = 1'b0;
        burst_len    = 8'd3;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        burst_len = 8'd7;
        start     = 1'b1;
        tick();
        start        = 1'b0;
        burst_len    = 8'd0;
        s_if.m_ready = 1'b1;
        run_until_done(40, ok);
        tick();
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL ignore_done_seen: got none expected done within 40 cycles");
        end
        n_cmp++;
        if ((got_q.size() != 3) || (rd_cyc_q.size() != 3)) begin
            n_err++;
            $display("FAIL ignore_beats: got %0d beats %0d reads expected 3 and 3", got_q.size(), rd_cyc_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL ignore_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if ((words_sent !== 8'd3) || (done_cnt != 1)) begin
            n_err++;
            $display("FAIL ignore_words_sent: got %0d done x%0d expected 3 done x1", words_sent, done_cnt);
        end
    endtask

    task automatic test_underflow();
        bit ok;
        clear_obs();
        for (int i = 1; i <= 3; i++) begin
            push_word(16'h0D00 + W'(i));
            exp_q.push_back(16'h0D00 + W'(i));
        end
        uf_force_idx = rd_resp_idx + 2;
        s_if.m_ready = 1'b1;
        burst_len    = 8'd3;
        start        = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(40, ok);
        uf_force_idx = -1;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL uf_done_seen: got none expected done within 40 cycles");
        end
        n_cmp++;
        if (err_underflow !== 1'b1) begin
            n_err++;
            $display("FAIL uf_flag_set: got %b expected 1", err_underflow);
        end
        n_cmp++;
        if ((got_q.size() != 3) || (rd_cyc_q.size() != 4)) begin
            n_err++;
            $display("FAIL uf_counts: got %0d beats %0d reads expected 3 and 4", got_q.size(), rd_cyc_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL uf_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (words_sent !== 8'd3) begin
            n_err++;
            $display("FAIL uf_words_sent: got %0d expected 3", words_sent);
        end
        repeat (3) tick();
        n_cmp++;
        if (err_underflow !== 1'b1) begin
            n_err++;
            $display("FAIL uf_flag_sticky: got %b expected 1", err_underflow);
        end
        clear_obs();
        push_word(16'h0D04);
        exp_q.push_back(16'h0D04);
        burst_len = 8'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (err_underflow !== 1'b0) begin
            n_err++;
            $display("FAIL uf_flag_cleared: got %b expected 0", err_underflow);
        end
        run_until_done(40, ok);
        n_cmp++;
        if (!ok || (got_q.size() != 1) || (got_q[0] !== exp_q[0])) begin
            n_err++;
            $display("FAIL uf_after_clear: got %0d beats expected 1 beat of %h", got_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs();
        for (int i = 1; i <= 4; i++) push_word(16'h0E00 + W'(i));
        s_if.m_ready = 1'b0;
        burst_len    = 8'd4;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if ((s_if.m_valid !== 1'b1) || (s_if.m_data !== 16'h0E01) || (busy !== 1'b1)) begin
            n_err++;
            $display("FAIL mid_pre_reset: got valid %b data %h busy %b expected 1 0e01 1",
                     s_if.m_valid, s_if.m_data, busy);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, rd_en, s_if.m_valid, s_if.m_last, err_underflow} !== 6'b0) begin
            n_err++;
            $display("FAIL mid_reset_flags: got %b expected 000000",
                     {busy, done, rd_en, s_if.m_valid, s_if.m_last, err_underflow});
        end
        n_cmp++;
        if ((s_if.m_data !== 16'h0000) || (words_sent !== 8'd0) || (dbg_state !== 2'd0)) begin
            n_err++;
            $display("FAIL mid_reset_values: got data %h sent %0d state %0d expected 0 0 0",
                     s_if.m_data, words_sent, dbg_state);
        end
        rst = 1'b0;
        fifo_q.delete();
        empty = 1'b1;
        tick();
        clear_obs();
        push_word(16'h0F01);
        push_word(16'h0F02);
        exp_q.push_back(16'h0F01);
        exp_q.push_back(16'h0F02);
        s_if.m_ready = 1'b1;
        burst_len    = 8'd2;
        start        = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(40, ok);
        n_cmp++;
        if (!ok || (got_q.size() != 2)) begin
            n_err++;
            $display("FAIL mid_restart: got %0d beats expected 2", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL mid_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (words_sent !== 8'd2) begin
            n_err++;
            $display("FAIL mid_words_sent: got %0d expected 2", words_sent);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        burst_len    = '0;
        data_out     = '0;
        underflow    = 1'b0;
        empty        = 1'b1;
        s_if.m_ready = 1'b0;
        clear_obs();
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_stall();
        test_zero_and_ignore();
        test_underflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
